// File: rtl/i2c_pkg.sv
// i2c_pkg: FSM states and bus-level constants shared by the I2C target and master
package i2c_pkg;
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, IGNORE
  } state_t;
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: 2-flop sync, optional glitch filter and registered rise/fall detect for one I2C line
//   clk, rst  : system clock, synchronous active-high reset
//   pin       : raw bus line
//   lvl       : conditioned line level, aligned with rise/fall
//   rise/fall : 1-clk edge pulses (3 clk after the pin, 3+FILT_LEN with I2C_SLAVE_GLITCH_FILTER_EN)
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic lvl,
  output logic rise,
  output logic fall
);
  logic [1:0] sync;
  logic acc;
  always_ff @(posedge clk)
    if (rst) sync <= 2'b11;
    else sync <= {sync[0], pin};
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] cnt;
  // the accepted level flips only after FILT_LEN consecutive differing samples
  always_ff @(posedge clk)
    if (rst) begin
      acc <= 1'b1;
      cnt <= '0;
    end else if (sync[1] == acc) cnt <= '0;
    else if (cnt == 3'(FILT_LEN - 1)) begin
      acc <= sync[1];
      cnt <= '0;
    end else cnt <= cnt + 3'd1;
`else
  logic unused_filt;
  assign unused_filt = |FILT_LEN;
  assign acc = sync[1];
`endif
  always_ff @(posedge clk)
    if (rst) begin
      lvl  <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      lvl  <= acc;
      rise <= acc & ~lvl;
      fall <= ~acc & lvl;
    end
endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: 7-bit I2C target with multi-byte write/read, repeated START, open-drain SDA
//   clk, rst            : system clock (>= 20x SCL), synchronous active-high reset
//   scl, sda            : I2C bus; sda driven 0 or released only
//   wr_data, wr_valid   : received byte and its 1-clk strobe
//   rd_req, rd_data     : request pulse for the next transmit byte, and that byte
//   busy                : addressed transfer in progress
//   start_det, stop_det : 1-clk bus condition pulses
//   Optional glitch filter: define I2C_SLAVE_GLITCH_FILTER_EN
module i2c_slave #(
  parameter logic [6:0] ADDR     = 7'h50,
  parameter int         FILT_LEN = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       start_det,
  output logic       stop_det
);
  import i2c_pkg::*;
  logic scl_lvl, scl_rise, scl_fall, sda_lvl, sda_rise, sda_fall;
  logic start, stop, match, done, sda_low;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [6:0] tx;
  state_t state;
  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .clk(clk), .rst(rst), .pin(scl), .lvl(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );
  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .clk(clk), .rst(rst), .pin(sda), .lvl(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );
  assign start = sda_fall & scl_lvl;
  assign stop  = sda_rise & scl_lvl;
  assign match = shreg[7:1] == ADDR;
  // rst gates the driver directly so a reset releases the bus without waiting for a clock edge
  assign sda   = (sda_low && !rst) ? 1'b0 : 1'bz;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx        <= '0;
      done      <= 1'b0;
      sda_low   <= 1'b0;
      wr_data   <= '0;
      wr_valid  <= 1'b0;
      rd_req    <= 1'b0;
      busy      <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      rd_req    <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      if (start) begin
        state     <= i2c_pkg::ADDR;
        bit_cnt   <= 3'd7;
        done      <= 1'b0;
        sda_low   <= 1'b0;
        start_det <= 1'b1;
      end else if (stop) begin
        state    <= IDLE;
        done     <= 1'b0;
        sda_low  <= 1'b0;
        busy     <= 1'b0;
        stop_det <= 1'b1;
      end else case (state)
        i2c_pkg::ADDR:
          if (scl_rise && !done) begin
            shreg   <= {shreg[6:0], sda_lvl};
            bit_cnt <= bit_cnt - 3'd1;
            done    <= bit_cnt == 3'd0;
            rd_req  <= bit_cnt == 3'd0 && shreg[6:0] == ADDR && sda_lvl;
          end else if (scl_fall && done) begin
            done    <= 1'b0;
            sda_low <= match;
            busy    <= match;
            state   <= match ? ADDR_ACK : IGNORE;
          end
        ADDR_ACK:
          if (scl_fall) begin
            bit_cnt <= 3'd7;
            tx      <= rd_data[6:0];
            sda_low <= shreg[0] & ~rd_data[7];
            state   <= shreg[0] ? READ : WRITE;
          end
        WRITE:
          if (scl_rise && !done) begin
            shreg   <= {shreg[6:0], sda_lvl};
            bit_cnt <= bit_cnt - 3'd1;
            done    <= bit_cnt == 3'd0;
            if (bit_cnt == 3'd0) begin
              wr_data  <= {shreg[6:0], sda_lvl};
              wr_valid <= 1'b1;
            end
          end else if (scl_fall && done) begin
            done    <= 1'b0;
            sda_low <= 1'b1;
            state   <= WRITE_ACK;
          end
        WRITE_ACK:
          if (scl_fall) begin
            sda_low <= 1'b0;
            bit_cnt <= 3'd7;
            state   <= WRITE;
          end
        READ:
          if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              sda_low <= 1'b0;
              state   <= READ_ACK;
            end else begin
              sda_low <= ~tx[6];
              tx      <= {tx[5:0], 1'b0};
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
        READ_ACK:
          if (scl_rise && !done) begin
            rd_req <= sda_lvl == ACK;
            done   <= sda_lvl == ACK;
            busy   <= sda_lvl == ACK;
            state  <= sda_lvl == ACK ? READ_ACK : IGNORE;
          end else if (scl_fall && done) begin
            done    <= 1'b0;
            tx      <= rd_data[6:0];
            sda_low <= ~rd_data[7];
            bit_cnt <= 3'd7;
            state   <= READ;
          end
        IGNORE: sda_low <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master driving the i2c_slave target with directed vectors
module tb_i2c_slave;
  import i2c_pkg::*;
  typedef struct {
    logic [7:0] ab;
    logic [7:0] d;
    logic       ack;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, m_low = 1'b0;
  logic [7:0] rd_data = 8'h00;
  logic [7:0] wr_data, exp_wr = 8'h00;
  logic wr_valid, rd_req, busy, start_det, stop_det;
  wire sda;
  int pass = 0, total = 0, n_wv = 0, n_rr = 0, n_st = 0, n_sp = 0, n_drv = 0;
  vec_t v[5];
  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);
  always #5 clk = ~clk;
  i2c_slave dut (
    .clk(clk), .rst(rst), .scl(scl_m), .sda(sda), .wr_data(wr_data), .wr_valid(wr_valid),
    .rd_req(rd_req), .rd_data(rd_data), .busy(busy), .start_det(start_det), .stop_det(stop_det)
  );
  always @(negedge clk) begin
    if (wr_valid) n_wv++;
    if (rd_req) n_rr++;
    if (start_det) n_st++;
    if (stop_det) n_sp++;
    if (!m_low && sda === 1'b0) n_drv++;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wbit(input logic b);
    m_low = !b;
    clks(10);
    scl_m = 1'b1;
    clks(20);
    scl_m = 1'b0;
    clks(5);
  endtask
  task automatic rbit(output logic b);
    m_low = 1'b0;
    clks(10);
    scl_m = 1'b1;
    clks(10);
    b = sda;
    clks(10);
    scl_m = 1'b0;
    clks(5);
  endtask
  task automatic bus_start();
    m_low = 1'b0;
    scl_m = 1'b1;
    clks(15);
    m_low = 1'b1;
    clks(15);
    scl_m = 1'b0;
    clks(5);
  endtask
  task automatic bus_stop();
    m_low = 1'b1;
    clks(10);
    scl_m = 1'b1;
    clks(15);
    m_low = 1'b0;
    clks(15);
  endtask
  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    rbit(a);
  endtask
  task automatic recv_byte(input logic [7:0] nxt, input logic ack, output logic [7:0] b);
    logic t;
    for (int i = 7; i >= 0; i--) begin
      rbit(t);
      b[i] = t;
    end
    rd_data = nxt;
    wbit(ack);
  endtask
  task automatic xfer(input vec_t x);
    logic a;
    int wv0, sp0, drv0;
    wv0 = n_wv; sp0 = n_sp; drv0 = n_drv;
    if (x.ack == ACK) exp_wr = x.d;
    bus_start();
    send_byte(x.ab, a);
    chk($sformatf("addr_ack_%02h", x.ab), 32'(a), 32'(x.ack));
    send_byte(x.d, a);
    chk($sformatf("data_ack_%02h", x.d), 32'(a), 32'(x.ack));
    chk("state_after_data", 32'(dut.state), x.ack == ACK ? 32'(WRITE) : 32'(IGNORE));
    chk("busy_in_xfer", 32'(busy), 32'(x.ack == ACK));
    bus_stop();
    chk("wr_valid_pulses", 32'(n_wv - wv0), 32'(x.ack == ACK));
    chk("wr_data", 32'(wr_data), 32'(exp_wr));
    chk("busy_after_stop", 32'(busy), 32'd0);
    chk("stop_det_pulses", 32'(n_sp - sp0), 32'd1);
    chk("sda_driven", 32'(n_drv > drv0), 32'(x.ack == ACK));
    chk("state_after_stop", 32'(dut.state), 32'(IDLE));
  endtask
  initial begin
    logic a;
    logic [7:0] b;
    int rr0, st0, sp0, wv0;
    v[0] = '{8'hA0, 8'hA5, ACK};
    v[1] = '{8'hA2, 8'hA5, NACK};
    v[2] = '{8'hA0, 8'h00, ACK};
    v[3] = '{8'hA0, 8'hFF, ACK};
    v[4] = '{8'h22, 8'h5A, NACK};
    clks(5);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_flags", 32'({wr_valid, rd_req, busy, start_det, stop_det}), 32'd0);
    chk("rst_sda", 32'(sda), 32'd1);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_bit_cnt", 32'(dut.bit_cnt), 32'd0);
    rst = 1'b0;
    clks(10);
    for (int i = 0; i < 5; i++) xfer(v[i]);
    // read 0x3C then 0xC3, master ACKs the first and NACKs the second
    rr0 = n_rr;
    rd_data = 8'h3C;
    bus_start();
    send_byte(8'hA1, a);
    chk("rd_addr_ack", 32'(a), 32'(ACK));
    chk("rd_busy", 32'(busy), 32'd1);
    recv_byte(8'hC3, ACK, b);
    chk("rd_byte0", 32'(b), 32'h3C);
    recv_byte(8'h00, NACK, b);
    chk("rd_byte1", 32'(b), 32'hC3);
    chk("rd_req_pulses", 32'(n_rr - rr0), 32'd2);
    chk("rd_state_nack", 32'(dut.state), 32'(IGNORE));
    chk("rd_busy_nack", 32'(busy), 32'd0);
    bus_stop();
    chk("rd_state_stop", 32'(dut.state), 32'(IDLE));
    // write 0x11, repeated START, read 0x5A
    st0 = n_st; wv0 = n_wv;
    rd_data = 8'h5A;
    bus_start();
    send_byte(8'hA0, a);
    chk("rs_addr_w_ack", 32'(a), 32'(ACK));
    send_byte(8'h11, a);
    chk("rs_data_ack", 32'(a), 32'(ACK));
    bus_start();
    send_byte(8'hA1, a);
    chk("rs_addr_r_ack", 32'(a), 32'(ACK));
    recv_byte(8'h00, NACK, b);
    chk("rs_rd_byte", 32'(b), 32'h5A);
    bus_stop();
    chk("rs_start_pulses", 32'(n_st - st0), 32'd2);
    chk("rs_wr_valid", 32'(n_wv - wv0), 32'd1);
    chk("rs_wr_data", 32'(wr_data), 32'h11);
    exp_wr = 8'h11;
    // reset while the target is driving bit 7 = 0 of a read
    rd_data = 8'h00;
    bus_start();
    send_byte(8'hA1, a);
    chk("mr_addr_ack", 32'(a), 32'(ACK));
    chk("mr_sda_driven", 32'(sda), 32'd0);
    rst = 1'b1;
    #1;
    chk("mr_sda_release", 32'(sda), 32'd1);
    clks(1);
    chk("mr_state", 32'(dut.state), 32'(IDLE));
    chk("mr_flags", 32'({wr_valid, rd_req, busy, start_det, stop_det}), 32'd0);
    chk("mr_wr_data", 32'(wr_data), 32'd0);
    chk("mr_sda_after", 32'(sda), 32'd1);
    exp_wr = 8'h00;
    clks(2);
    rst = 1'b0;
    clks(10);
    xfer('{8'hA0, 8'h5A, ACK});
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    st0 = n_st; sp0 = n_sp;
    @(negedge clk) m_low = 1'b1;
    @(negedge clk) m_low = 1'b0;
    clks(20);
    chk("glitch_no_start", 32'(n_st - st0), 32'd0);
    chk("glitch_no_stop", 32'(n_sp - sp0), 32'd0);
    @(negedge clk) m_low = 1'b1;
    clks(20);
    chk("long_low_start", 32'(n_st - st0), 32'd1);
    scl_m = 1'b0;
    clks(10);
    bus_stop();
    chk("long_low_stop", 32'(n_sp - sp0), 32'd1);
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
